// File: rtl/controle_pausa.sv
// Execution-mode controller driving the pause[1:0] selector of the processor clock generator.
// Optional macro PAUSA_OUT_EN: OUT instructions stop the processor in WAIT_OUT.
module controle_pausa #(
  parameter int unsigned LARGURA_DADO   = 16,
  parameter int unsigned LARGURA_CICLOS = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clock_proc,
  input  logic                      instr_in,
  input  logic                      instr_out,
  input  logic                      instr_halt,
  input  logic [LARGURA_DADO-1:0]   valor_out,
  output logic [1:0]                pause,
  output logic [LARGURA_DADO-1:0]   dado_out,
  output logic                      espera_in,
  output logic                      espera_out,
  output logic                      parado,
  output logic [LARGURA_CICLOS-1:0] ciclos
);

  typedef enum logic [1:0] {StRun, StWaitIn, StWaitOut, StHalt} estado_e;

  estado_e                   estado_q, estado_d;
  logic                      clock_proc_q;
  logic                      sobe;
  logic                      latch_out;
  logic [LARGURA_DADO-1:0]   dado_q;
  logic [LARGURA_CICLOS-1:0] ciclos_q;

  // clock_proc comes from a clock-domain register, so a one-stage edge detect is enough
  assign sobe = clock_proc & ~clock_proc_q;

  always_comb begin
    estado_d  = estado_q;
    latch_out = 1'b0;
    case (estado_q)
      StRun: begin
        if (instr_halt) begin
          estado_d = StHalt;
        end else if (instr_in) begin
          estado_d = StWaitIn;
        end else if (instr_out) begin
          latch_out = 1'b1;
`ifdef PAUSA_OUT_EN
          estado_d  = StWaitOut;
`endif
        end
      end
      StWaitIn, StWaitOut: begin
        if (sobe) estado_d = StRun;
      end
      StHalt:  estado_d = StHalt;
      default: estado_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= StRun;
      clock_proc_q <= 1'b0;
      dado_q       <= '0;
      ciclos_q     <= '0;
    end else begin
      estado_q     <= estado_d;
      clock_proc_q <= clock_proc;
      if (latch_out) dado_q <= valor_out;
      if (sobe && (estado_q != StHalt)) ciclos_q <= ciclos_q + LARGURA_CICLOS'(1);
    end
  end

  always_comb begin
    pause      = 2'd1;
    espera_in  = 1'b0;
    espera_out = 1'b0;
    parado     = 1'b0;
    case (estado_q)
      StWaitIn: begin
        pause     = 2'd0;
        espera_in = 1'b1;
      end
      StWaitOut: begin
        pause = 2'd2;
`ifdef PAUSA_OUT_EN
        espera_out = 1'b1;
`else
        espera_out = 1'b0;
`endif
      end
      StHalt: begin
        pause  = 2'd3;
        parado = 1'b1;
      end
      default: pause = 2'd1;
    endcase
  end

  assign dado_out = dado_q;
  assign ciclos   = ciclos_q;

endmodule

// File: tb/tb_controle_pausa.sv
// Directed self-checking bench for controle_pausa (counter narrowed so the wrap test stays short).
module tb_controle_pausa;

  localparam int unsigned LD = 16;
  localparam int unsigned LC = 10;
  localparam logic [LC-1:0] CICLOS_MAX = '1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clock_proc;
  logic          instr_in, instr_out, instr_halt;
  logic [LD-1:0] valor_out;
  logic [1:0]    pause;
  logic [LD-1:0] dado_out;
  logic          espera_in, espera_out, parado;
  logic [LC-1:0] ciclos;

  int            n_vec = 0;
  int            n_err = 0;
  logic [LC-1:0] exp_ciclos;
  logic [LD-1:0] exp_dado;

  controle_pausa #(
    .LARGURA_DADO  (LD),
    .LARGURA_CICLOS(LC)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock_proc(clock_proc),
    .instr_in  (instr_in),
    .instr_out (instr_out),
    .instr_halt(instr_halt),
    .valor_out (valor_out),
    .pause     (pause),
    .dado_out  (dado_out),
    .espera_in (espera_in),
    .espera_out(espera_out),
    .parado    (parado),
    .ciclos    (ciclos)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulso_proc();
    clock_proc = 1'b1;
    tick();
    clock_proc = 1'b0;
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    clock_proc = 1'b0;
    instr_in   = 1'b1;
    instr_out  = 1'b0;
    instr_halt = 1'b0;
    valor_out  = '0;
    exp_ciclos = '0;
    exp_dado   = '0;
    tick();
    tick();
    check_eq("rst_pause", 32'(pause), 32'd1);
    check_eq("rst_dado", 32'(dado_out), 32'd0);
    check_eq("rst_ciclos", 32'(ciclos), 32'd0);
    check_eq("rst_espera_in", 32'(espera_in), 32'd0);
    check_eq("rst_parado", 32'(parado), 32'd0);

    reset_n = 1'b1;
    tick();
    check_eq("in_pause", 32'(pause), 32'd0);
    check_eq("in_espera", 32'(espera_in), 32'd1);

    // Flags are ignored while waiting for IN
    instr_halt = 1'b1;
    tick();
    check_eq("in_ignore_halt", 32'(pause), 32'd0);
    check_eq("in_ignore_parado", 32'(parado), 32'd0);
    instr_halt = 1'b0;

    clock_proc = 1'b1;
    tick();
    exp_ciclos = exp_ciclos + 1'b1;
    check_eq("in_exit_pause", 32'(pause), 32'd1);
    check_eq("in_exit_ciclos", 32'(ciclos), 32'(exp_ciclos));
    tick();
    check_eq("in_reenter", 32'(pause), 32'd0);
    check_eq("in_reenter_ciclos", 32'(ciclos), 32'(exp_ciclos));

    instr_in   = 1'b0;
    clock_proc = 1'b0;
    tick();
    check_eq("in_hold", 32'(pause), 32'd0);
    clock_proc = 1'b1;
    tick();
    exp_ciclos = exp_ciclos + 1'b1;
    check_eq("in_exit2", 32'(pause), 32'd1);
    clock_proc = 1'b0;
    tick();

`ifdef PAUSA_OUT_EN
    valor_out = 16'hBEEF;
    instr_out = 1'b1;
    tick();
    exp_dado = 16'hBEEF;
    check_eq("out_pause", 32'(pause), 32'd2);
    check_eq("out_espera", 32'(espera_out), 32'd1);
    check_eq("out_dado", 32'(dado_out), 32'(exp_dado));
    instr_out = 1'b0;
    valor_out = 16'h1234;
    tick();
    check_eq("out_hold_dado", 32'(dado_out), 32'(exp_dado));
    check_eq("out_hold_pause", 32'(pause), 32'd2);
    clock_proc = 1'b1;
    tick();
    exp_ciclos = exp_ciclos + 1'b1;
    check_eq("out_exit_pause", 32'(pause), 32'd1);
    check_eq("out_exit_espera", 32'(espera_out), 32'd0);
    clock_proc = 1'b0;
    tick();
`else
    valor_out = 16'h00A5;
    instr_out = 1'b1;
    tick();
    exp_dado = 16'h00A5;
    check_eq("out_pause", 32'(pause), 32'd1);
    check_eq("out_espera", 32'(espera_out), 32'd0);
    check_eq("out_dado", 32'(dado_out), 32'(exp_dado));
    instr_out = 1'b0;
    valor_out = 16'h1234;
    tick();
    check_eq("out_hold_dado", 32'(dado_out), 32'(exp_dado));
`endif
    check_eq("ciclos_after_out", 32'(ciclos), 32'(exp_ciclos));

    // sobe and a new IN flag on the same edge: count and transition both happen
    clock_proc = 1'b1;
    instr_in   = 1'b1;
    tick();
    exp_ciclos = exp_ciclos + 1'b1;
    check_eq("same_edge_pause", 32'(pause), 32'd0);
    check_eq("same_edge_ciclos", 32'(ciclos), 32'(exp_ciclos));
    clock_proc = 1'b0;
    instr_in   = 1'b0;
    tick();
    pulso_proc();
    exp_ciclos = exp_ciclos + 1'b1;
    check_eq("same_edge_exit", 32'(pause), 32'd1);

    while (exp_ciclos != CICLOS_MAX) begin
      pulso_proc();
      exp_ciclos = exp_ciclos + 1'b1;
    end
    check_eq("wrap_max", 32'(ciclos), 32'(CICLOS_MAX));
    pulso_proc();
    check_eq("wrap_zero", 32'(ciclos), 32'd0);

    instr_in   = 1'b1;
    instr_out  = 1'b1;
    instr_halt = 1'b1;
    valor_out  = 16'h5555;
    tick();
    check_eq("halt_pause", 32'(pause), 32'd3);
    check_eq("halt_parado", 32'(parado), 32'd1);
    check_eq("halt_espera_in", 32'(espera_in), 32'd0);
    check_eq("halt_dado", 32'(dado_out), 32'(exp_dado));
    instr_in   = 1'b0;
    instr_out  = 1'b0;
    instr_halt = 1'b0;
    pulso_proc();
    pulso_proc();
    check_eq("halt_ciclos", 32'(ciclos), 32'd0);
    check_eq("halt_stay", 32'(pause), 32'd3);

    // Asynchronous reset out of HALT, checked before the next clock edge
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("arst_pause", 32'(pause), 32'd1);
    check_eq("arst_parado", 32'(parado), 32'd0);
    check_eq("arst_dado", 32'(dado_out), 32'd0);
    check_eq("arst_ciclos", 32'(ciclos), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_pause", 32'(pause), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
